// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard sequencer.
// The master side is the datapath: it reports cache/hazard status and consumes
// latch enables/flushes. The slave side is the sequencer that answers it.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  // status reported by the datapath
  logic             ihit;
  logic             dhit;
  logic             mem_dREN;
  logic             mem_dWEN;
  logic             mem_redirect;
  logic             mem_halt;
  logic             ex_dREN;
  logic [4:0]       ex_rt;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;

  // control returned by the sequencer
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             memwb_flush;
  logic             halt;
  logic             dwait_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, mem_redirect, mem_halt,
           ex_dREN, ex_rt, id_rs, id_rt,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, memwb_flush,
           halt, dwait_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, mem_redirect, mem_halt,
           ex_dREN, ex_rt, id_rs, id_rt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, memwb_flush,
           halt, dwait_timeout, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline latches.
// Turns cache hits, load-use hazards, MEM-stage redirects and halt into per-latch
// enable/flush plus PC enable, runs the halt drain FSM and keeps saturating
// stall/flush event counters. All outputs are combinational from state + inputs.
module pipeline_hazard_ctrl #(
  parameter int CNT_W     = 32,
  parameter int DWAIT_MAX = 255   // 0 disables the timeout pulse
) (
  input logic                   CLK,
  input logic                   nRST,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DWAIT  = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  // The DWAIT counter holds the number of frozen cycles including the current
  // one, so it must reach DWAIT_MAX+1 to stop re-matching after the pulse.
  localparam int            DW_W       = $clog2(DWAIT_MAX + 2);
  localparam logic [DW_W-1:0] DW_MAX   = DW_W'(DWAIT_MAX);
  localparam logic [DW_W-1:0] DW_SAT   = DW_W'(DWAIT_MAX + 1);
  localparam logic [DW_W-1:0] DW_ONE   = DW_W'(1);
  localparam bit            TIMEOUT_EN = (DWAIT_MAX != 0);

  state_e           state_q, state_d;
  logic [DW_W-1:0]  dwait_cnt_q, dwait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic dmem_busy;
  logic load_use;
  logic resolve;
  logic redirect_fire;
  logic stall_any;

  logic pc_en;
  logic ifid_en, ifid_flush;
  logic idex_en, idex_flush;
  logic exmem_en, exmem_flush;
  logic memwb_en, memwb_flush;
  logic halt;
  logic dwait_timeout;

  // Hazard detectors: outstanding dcache access and load-use on a non-zero rt.
  always_comb begin
    dmem_busy = (bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit;
    load_use  = bus.ex_dREN & (bus.ex_rt != 5'd0) &
                ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));
  end

  // Next-state and latch control: frozen default, then state and priority rules.
  always_comb begin
    state_d       = state_q;
    dwait_cnt_d   = dwait_cnt_q;
    resolve       = 1'b0;
    redirect_fire = 1'b0;
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    ifid_flush    = 1'b0;
    idex_en       = 1'b0;
    idex_flush    = 1'b0;
    exmem_en      = 1'b0;
    exmem_flush   = 1'b0;
    memwb_en      = 1'b0;
    memwb_flush   = 1'b0;
    halt          = 1'b0;
    dwait_timeout = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (dmem_busy) begin
          // This cycle is the first frozen one, so the count starts at 1.
          state_d     = S_DWAIT;
          dwait_cnt_d = DW_ONE;
        end else begin
          resolve = 1'b1;
        end
      end
      S_DWAIT: begin
        dwait_timeout = TIMEOUT_EN && (dwait_cnt_q == DW_MAX);
        if (!bus.dhit) begin
          if (dwait_cnt_q != DW_SAT) begin
            dwait_cnt_d = dwait_cnt_q + DW_ONE;
          end
        end else begin
          // Data arrives this cycle: release the freeze and let the
          // remaining rules decide how the latches move on this edge.
          dwait_cnt_d = '0;
          state_d     = S_RUN;
          resolve     = 1'b1;
        end
      end
      S_DRAIN: begin
        // MEM/WB keeps the halt instruction; everything else frozen.
        state_d = S_HALTED;
      end
      S_HALTED: begin
        halt = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    if (resolve) begin
      if (bus.mem_halt) begin
        // Retire the halt into MEM/WB and squash everything behind it.
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        state_d     = S_DRAIN;
      end else if (bus.mem_redirect) begin
        // Load the target; younger instructions are wrong-path, so a
        // pending load-use bubble or fetch miss no longer matters.
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        ifid_flush    = 1'b1;
        idex_en       = 1'b1;
        idex_flush    = 1'b1;
        exmem_en      = 1'b1;
        exmem_flush   = 1'b1;
        memwb_en      = 1'b1;
        redirect_fire = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, insert a bubble into ID/EX.
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else if (!bus.ihit) begin
        // Hold PC to retry the fetch; IF/ID takes a bubble meanwhile.
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
  end

  // Saturating event counters; HALTED cycles are not stalls.
  always_comb begin
    stall_any   = ~(pc_en & ifid_en & idex_en & exmem_en & memwb_en);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_any && (state_q != S_HALTED) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redirect_fire && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= S_RUN;
      dwait_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dwait_cnt_q <= dwait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // While reset is held every latch loads bubbles and the PC stays put,
  // independent of the registered state.
  assign bus.pc_en         = nRST & pc_en;
  assign bus.ifid_en       = nRST & ifid_en;
  assign bus.idex_en       = nRST & idex_en;
  assign bus.exmem_en      = nRST & exmem_en;
  assign bus.memwb_en      = nRST & memwb_en;
  assign bus.ifid_flush    = ~nRST | ifid_flush;
  assign bus.idex_flush    = ~nRST | idex_flush;
  assign bus.exmem_flush   = ~nRST | exmem_flush;
  assign bus.memwb_flush   = ~nRST | memwb_flush;
  assign bus.halt          = nRST & halt;
  assign bus.dwait_timeout = nRST & dwait_timeout;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.flush_cnt     = flush_cnt_q;

endmodule
